fir_stream_ctrl: RTL
====================

# fir_stream_ctrl

Sequencer and configuration controller for the parameterized FIR filter datapath. It owns the filter's coefficient bus through a shadow/active double-buffered bank, so software can load taps and swap them atomically. It drives the filter's sample input from a valid/ready stream, inserting zeros on underrun or drain. It also qualifies the filter output with a valid strobe aligned to filter latency. It sits between the host/config side and one `fir_filter_parameterized` instance.

## Interface
- `n`, 2: filter order; the filter has n+1 taps
- `w_x`, 8: sample width, signed
- `w_h`, 8: coefficient width, signed
- `LAT`, 1: filter latency in cycles, from `x` change to the corresponding `y`
- `clk`  in  1: single clock, rising edge
- `reset`  in  1: asynchronous, active-high reset
- `cw_valid`  in  1: coefficient write strobe (no ready; always accepted)
- `cw_idx`  in  $clog2(n+1): tap index
- `cw_data`  in  w_h: coefficient value
- `cmt`  in  1: commit pulse, copies shadow bank to active bank
- `start` / `stop`  in  1 each: run control pulses
- `clr`  in  1: clears the sticky flags
- `s_valid`  in  1, `s_data`  in  w_x, `s_ready`  out  1: sample stream
- `x`  out  w_x: to filter, registered
- `Hz`  out  (n+1)*w_h: to filter, active bank; tap k at `[k*w_h +: w_h]`
- `y`  in  w_x+w_h+n: from filter
- `m_valid`  out  1, `m_data`  out  w_x+w_h+n: qualified output, registered
- `busy`  out  1: high in RUN or DRAIN
- `underrun`, `cfg_err`  out  1 each: sticky flags

## Operation
- Reset values: state IDLE; `x`=0, `Hz`=0, shadow bank=0, `s_ready`=0, `m_valid`=0, `m_data`=0, `busy`=0, `underrun`=0, `cfg_err`=0. A mid-operation reset aborts immediately and clears all in-flight valid bits.
- States:
  - IDLE: `s_ready`=0, `x`<=0.
  - RUN: `s_ready`=1. Each edge `x` <= `s_valid` ? `s_data` : 0. If `s_valid`=0, set `underrun`.
  - DRAIN: `x`<=0 for LAT+1 cycles, then go to IDLE.
- Transitions:
  - IDLE+`start` -> RUN.
  - RUN+`stop` -> DRAIN. If `start` and `stop` arrive together, `stop` wins.
  - `start` in RUN/DRAIN is ignored; `stop` in IDLE/DRAIN is ignored.
  - `start` also clears both sticky flags.
- Coefficient writes and `cmt` are legal in any state.
  - `cw_valid` with `cw_idx`>n: write dropped, `cfg_err` set.
  - `cmt`: `Hz` <= shadow bank as it stood before the edge. A `cw_valid` on the same edge lands in the shadow bank only.
- Valid pipeline: a shift register LAT+1 deep, fed with 1 for each accepted sample and 0 for inserted zeros. Its tail loads `m_valid`; `m_data` <= `y` on every edge.
- `clr` and a flag-setting event on the same edge: the set wins.

## Timing
- A sample accepted at edge k appears on `x` after edge k. `m_valid`/`m_data` for that sample appear after edge k+LAT+1.
- Commit takes effect on `Hz` one edge after `cmt`. Outputs from then on use the new taps applied over the existing sample history; there is no flush.
- `busy` falls on the edge that DRAIN exits to IDLE.

## Configuration
- `FIR_CTRL_WARMUP_EN` defined: a saturating counter (0..n) counts accepted samples since `start`. `m_valid` is suppressed for the first n accepted samples, so only full-window outputs are flagged. Underrun zeros do not advance the counter.
- Macro undefined: every accepted sample produces `m_valid`, including start-up outputs that mix in zero history.

## Structure
- Package `fir_ctrl_pkg` holds:
  - `state_t` enum {IDLE, RUN, DRAIN}
  - function `fir_w_y(n, w_x, w_h)` = w_x+w_h+n
  - the index width constant
- Sub-module `fir_coeff_bank` holds the shadow and active registers, write decode, range check and commit. The top module holds the FSM, valid pipeline and flags.

## Test plan
All scenarios use n=2, LAT=1.
- Write taps 1, 2, 3 to idx 0..2, then `cmt` -> `Hz`=24'h030201 one edge later; `Hz` unchanged before the commit.
- With the taps committed and `FIR_CTRL_WARMUP_EN` defined: `start`, then stream 1, 2, 3, 4 -> `m_data` valid sequence 10, 16 (outputs 1 and 4 suppressed). With the macro undefined -> 1, 4, 10, 16.
- In RUN, drop `s_valid` for 1 cycle -> `underrun`=1, one zero on `x`, no `m_valid` for that slot; `clr` -> `underrun`=0.
- `cw_idx`=3 write -> `cfg_err`=1, shadow bank unchanged. `cw_valid` and `cmt` on the same edge -> `Hz` gets the old shadow value; a second `cmt` picks up the new write.
- `stop` mid-stream -> last sample's `m_valid` still emitted, `busy` low 2 cycles later. `start`+`stop` together in RUN -> enters DRAIN.
- Assert `reset` mid-RUN with samples in flight -> all outputs at reset values immediately, no stale `m_valid` after release.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types and sizing helpers for the FIR stream controller.
//   state_t    : controller FSM states (IDLE, RUN, DRAIN)
//   FIR_N      : default filter order (taps = FIR_N+1)
//   fir_w_y()  : width of the filter output for a given order / operand widths
//   fir_idx_w(): width of a tap index for a given order
//   FIR_IDX_W  : tap index width for the default order
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIR_N = 2;

  // Full-precision sum of n+1 products of w_x by w_h signed operands.
  function automatic int fir_w_y(input int n, input int w_x, input int w_h);
    return w_x + w_h + n;
  endfunction

  // A tap index must be able to address taps 0..n; never narrower than 1 bit.
  function automatic int fir_idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int FIR_IDX_W = fir_idx_w(FIR_N);

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered coefficient store for the FIR filter.
// Software writes taps into the shadow bank one at a time; a commit copies
// the whole shadow bank into the active bank in one edge, so the filter
// never sees a half-updated tap set.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   cw_valid          : tap write strobe (always accepted)
//   cw_idx, cw_data   : tap index and value
//   cmt               : commit pulse, active <= shadow as it stood before the edge
//   Hz                : active bank, tap k at [k*w_h +: w_h]
//   cw_err            : combinational, high when a write addresses a tap > n
module fir_coeff_bank
  import fir_ctrl_pkg::*;
#(
  parameter int n   = FIR_N,
  parameter int w_h = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cw_valid,
  input  logic [fir_idx_w(n)-1:0] cw_idx,
  input  logic [w_h-1:0]          cw_data,
  input  logic                    cmt,
  output logic [(n+1)*w_h-1:0]    Hz,
  output logic                    cw_err
);

  logic [(n+1)*w_h-1:0] shadow;
  logic                 idx_ok;

  // The index field can encode more values than there are taps.
  assign idx_ok = (int'(cw_idx) <= n);
  assign cw_err = cw_valid && !idx_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k <= n; k++) begin
        if (cw_valid && idx_ok && (int'(cw_idx) == k)) begin
          shadow[k*w_h +: w_h] <= cw_data;
        end
      end
    end
  end

  // Non-blocking read of shadow: a write on the same edge as a commit
  // lands only in the shadow bank and waits for the next commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Hz <= '0;
    end else if (cmt) begin
      Hz <= shadow;
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequencer and configuration controller for one
// fir_filter_parameterized instance.
//   - feeds the filter sample input x from a valid/ready stream, inserting
//     zeros when the stream underruns and while draining
//   - owns the filter coefficient bus Hz via a shadow/active bank
//   - qualifies the filter output y with m_valid, aligned to filter latency
//
// Build option: define FIR_CTRL_WARMUP_EN to suppress m_valid for the first
// n accepted samples after start (only full-window outputs are flagged).
// Without it, every accepted sample produces an m_valid.
//
// Stream handshake (s_valid/s_ready): a sample transfers on a rising edge
// where both are high. s_ready is a function of the FSM state only (high in
// RUN) and never depends on s_valid. When s_ready is high and s_valid is low,
// a zero is sent to the filter and underrun is flagged.
//
// Ports
//   clk, reset             : clock, asynchronous active-high reset
//   cw_valid/cw_idx/cw_data: coefficient write into the shadow bank
//   cmt                    : commit shadow bank to Hz
//   start, stop            : run control pulses (stop wins if both in RUN)
//   clr                    : clears sticky flags (a same-edge set wins)
//   s_valid/s_data/s_ready : input sample stream
//   x                      : registered sample to the filter
//   Hz                     : active coefficients to the filter
//   y                      : filter output
//   m_valid/m_data         : registered, qualified filter output
//   busy                   : high in RUN or DRAIN
//   underrun, cfg_err      : sticky flags
//   dbg_state              : current FSM state
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int n   = FIR_N,
  parameter int w_x = 8,
  parameter int w_h = 8,
  parameter int LAT = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cw_valid,
  input  logic [fir_idx_w(n)-1:0]           cw_idx,
  input  logic [w_h-1:0]                    cw_data,
  input  logic                              cmt,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              clr,
  input  logic                              s_valid,
  input  logic [w_x-1:0]                    s_data,
  output logic                              s_ready,
  output logic [w_x-1:0]                    x,
  output logic [(n+1)*w_h-1:0]              Hz,
  input  logic [fir_w_y(n, w_x, w_h)-1:0]   y,
  output logic                              m_valid,
  output logic [fir_w_y(n, w_x, w_h)-1:0]   m_data,
  output logic                              busy,
  output logic                              underrun,
  output logic                              cfg_err,
  output state_t                            dbg_state
);

  // Drain counter must reach LAT; keep at least one bit.
  localparam int DW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  state_t         state, state_nx;
  logic [DW-1:0]  drain_cnt;
  logic           drain_done;
  logic           acc;        // a sample is accepted this edge
  logic           feed;       // accepted sample that should raise m_valid
  logic [w_x-1:0] x_nx;
  logic           cw_err;
  logic           flag_clr;
  logic [LAT:0]   vpipe;
  logic [LAT+1:0] vshift;

  fir_coeff_bank #(
    .n   (n),
    .w_h (w_h)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .cw_valid (cw_valid),
    .cw_idx   (cw_idx),
    .cw_data  (cw_data),
    .cmt      (cmt),
    .Hz       (Hz),
    .cw_err   (cw_err)
  );

  assign dbg_state  = state;
  assign drain_done = (drain_cnt == DW'(LAT));

  // Next state and per-state outputs.
  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b0;
    acc      = 1'b0;
    x_nx     = '0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        acc     = s_valid;
        if (s_valid) x_nx = s_data;
        if (stop) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counts the zero-fill cycles spent in DRAIN; LAT+1 of them flush the
  // last real sample through the filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + DW'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
    end else begin
      x <= x_nx;
    end
  end

`ifdef FIR_CTRL_WARMUP_EN
  localparam int WW = fir_idx_w(n);
  logic [WW-1:0] warm_cnt;
  logic          warm_full;

  // warm_cnt is the number of samples already accepted since start,
  // saturating at n; the window is full once n older samples exist.
  assign warm_full = (warm_cnt == WW'(n));
  assign feed      = acc && warm_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      warm_cnt <= '0;
    end else if (acc && !warm_full) begin
      warm_cnt <= warm_cnt + WW'(1);
    end
  end
`else
  assign feed = acc;
`endif

  // vpipe[0] marks the sample just placed on x; vpipe[LAT] marks the one
  // whose result is on y now, so m_valid/m_data load together next edge.
  assign vshift = {vpipe, feed};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      vpipe   <= vshift[LAT:0];
      m_valid <= vpipe[LAT];
      m_data  <= y;
    end
  end

  // start only takes effect from IDLE, so only then does it clear flags.
  assign flag_clr = clr || ((state == IDLE) && start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if ((state == RUN) && !s_valid) begin
        underrun <= 1'b1;
      end else if (flag_clr) begin
        underrun <= 1'b0;
      end
      if (cw_err) begin
        cfg_err <= 1'b1;
      end else if (flag_clr) begin
        cfg_err <= 1'b0;
      end
    end
  end

endmodule
